// File: rtl/dff_pkg.sv
// Shared definitions for the universal register family: mode encodings.
// No logic, no latency; nothing here carries flow control.
// Shared by dff_ureg and its next-state function.
package dff_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_LOAD = 3'd1;
    localparam mode_t MODE_SHL  = 3'd2;
    localparam mode_t MODE_SHR  = 3'd3;
    localparam mode_t MODE_ROTL = 3'd4;
    localparam mode_t MODE_ROTR = 3'd5;
    localparam mode_t MODE_INC  = 3'd6;
    localparam mode_t MODE_DEC  = 3'd7;

endpackage

// File: rtl/dff_ureg_next.sv
// Next-state function for dff_ureg: load, shift, rotate and up/down count.
// Purely combinational, zero latency; no flow control.
// Shifts are written with operators instead of slices so that WIDTH=1 stays legal.
module dff_ureg_next
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] q,
    input  logic             cout,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] nxt_q,
    output logic             nxt_cout
);

    logic [WIDTH-1:0] sin_w;
    logic             all_ones;
    logic             all_zero;

    assign sin_w    = WIDTH'(sin);
    assign all_ones = &q;
    assign all_zero = ~|q;

    always_comb begin
        nxt_q    = q;
        nxt_cout = cout;
        case (mode)
            MODE_HOLD: begin
                nxt_q    = q;
                nxt_cout = cout;
            end
            MODE_LOAD: begin
                nxt_q    = d;
                nxt_cout = 1'b0;
            end
            MODE_SHL: begin
                nxt_q    = (q << 1) | sin_w;
                nxt_cout = q[WIDTH-1];
            end
            MODE_SHR: begin
                nxt_q    = (q >> 1) | (sin_w << (WIDTH - 1));
                nxt_cout = q[0];
            end
            MODE_ROTL: begin
                nxt_q    = (q << 1) | (q >> (WIDTH - 1));
                nxt_cout = q[WIDTH-1];
            end
            MODE_ROTR: begin
                nxt_q    = (q >> 1) | (q << (WIDTH - 1));
                nxt_cout = q[0];
            end
            // Saturating variants pin q at the boundary but still flag the carry/borrow.
            MODE_INC: begin
                nxt_q    = (SAT && all_ones) ? q : q + WIDTH'(1);
                nxt_cout = all_ones;
            end
            MODE_DEC: begin
                nxt_q    = (SAT && all_zero) ? q : q - WIDTH'(1);
                nxt_cout = all_zero;
            end
            default: begin
                nxt_q    = q;
                nxt_cout = cout;
            end
        endcase
    end

endmodule

// File: rtl/dff_ureg.sv
// WIDTH-bit universal register: async reset, sync clear/set, enable-gated mode ops.
// One cycle from inputs to q/cout; q_n is combinational from q.
// No backpressure: every enabled edge commits the selected operation.
module dff_ureg
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SAT       = 1'b0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             s,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             cout
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] op_q;
    logic             op_cout;

    dff_ureg_next #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_next (
        .q        (q_q),
        .cout     (cout_q),
        .mode     (mode),
        .d        (d),
        .sin      (sin),
        .nxt_q    (op_q),
        .nxt_cout (op_cout)
    );

    // clr wins over s; en only gates the mode operation.
    always_comb begin
        q_d    = q_q;
        cout_d = cout_q;
        if (clr) begin
            q_d    = '0;
            cout_d = 1'b0;
        end else if (s) begin
            q_d    = '1;
            cout_d = 1'b0;
        end else if (en) begin
            q_d    = op_q;
            cout_d = op_cout;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            q_q    <= RESET_VAL;
            cout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
        end
    end

    assign q    = q_q;
    assign q_n  = ~q_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_dff_ureg.sv
// Self-checking bench for dff_ureg: directed table, SAT corner cases, async reset, random vs model.
module tb_dff_ureg;

    logic       clk;
    logic       r, clr, s, en, sin;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q0, qn0, q1, qn1;
    logic       c0, c1;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] RV = 8'hA5;

    dff_ureg #(.WIDTH(8), .RESET_VAL(RV), .SAT(1'b0)) dut (
        .clk(clk), .r(r), .clr(clr), .s(s), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q0), .q_n(qn0), .cout(c0)
    );

    dff_ureg #(.WIDTH(8), .RESET_VAL(RV), .SAT(1'b1)) dut_s (
        .clk(clk), .r(r), .clr(clr), .s(s), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q1), .q_n(qn1), .cout(c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, s, en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;   // expected q, SAT=0
        logic       ec;
        logic [7:0] eqs;  // expected q, SAT=1
        logic       ecs;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [7:0] eq, input logic ec,
                              input logic [7:0] eqs, input logic ecs);
        check({name, " q"},     q0,  eq);
        check({name, " q_n"},   qn0, ~eq);
        check({name, " cout"},  {7'd0, c0}, {7'd0, ec});
        check({name, " qs"},    q1,  eqs);
        check({name, " qs_n"},  qn1, ~eqs);
        check({name, " couts"}, {7'd0, c1}, {7'd0, ecs});
    endtask

    task automatic drive(input logic i_clr, i_s, i_en, input logic [2:0] i_mode,
                         input logic [7:0] i_d, input logic i_sin);
        clr = i_clr; s = i_s; en = i_en; mode = i_mode; d = i_d; sin = i_sin;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: the specification's rules with plain integer arithmetic.
    task automatic model(input int sat, input int q, input int c, input bit m_clr, m_s, m_en,
                         input int m_mode, input int m_d, input int m_sin,
                         output int nq, output int nc);
        nq = q;
        nc = c;
        if (m_clr) begin
            nq = 0; nc = 0;
        end else if (m_s) begin
            nq = 255; nc = 0;
        end else if (m_en) begin
            case (m_mode)
                1: begin nq = m_d; nc = 0; end
                2: begin nc = q / 128; nq = (q * 2 + m_sin) % 256; end
                3: begin nc = q % 2; nq = q / 2 + m_sin * 128; end
                4: begin nc = q / 128; nq = (q * 2) % 256 + q / 128; end
                5: begin nc = q % 2; nq = q / 2 + (q % 2) * 128; end
                6: begin nc = (q == 255); nq = (q == 255) ? (sat ? 255 : 0) : q + 1; end
                7: begin nc = (q == 0); nq = (q == 0) ? (sat ? 0 : 255) : q - 1; end
                default: ;
            endcase
        end
    endtask

    function automatic vec_t mk(input logic i_clr, i_s, i_en, input logic [2:0] i_mode,
                                input logic [7:0] i_d, input logic i_sin,
                                input logic [7:0] eq, input logic ec,
                                input logic [7:0] eqs, input logic ecs);
        vec_t v;
        v.clr = i_clr; v.s = i_s; v.en = i_en; v.mode = i_mode; v.d = i_d; v.sin = i_sin;
        v.eq = eq; v.ec = ec; v.eqs = eqs; v.ecs = ecs;
        return v;
    endfunction

    initial begin
        int mq0, mc0, mq1, mc1, nq, nc;
        int rm, rd, rs, rsel;
        bit rclr, rs_b, ren;

        //             clr  s    en   mode  d      sin   q0     c0    q1     c1
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 8'h79, 1'b0, 8'h79, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 8'hF3, 1'b0, 8'hF3, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 8'h79, 1'b1, 8'h79, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 8'h81, 1'b0, 8'h81, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 8'h03, 1'b1, 8'h03, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'h81, 1'b1, 8'h81, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 8'hC0, 1'b1, 8'hC0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'hFE, 1'b0, 8'hFE, 1'b0, 8'hFE, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 8'hFF, 1'b1, 8'hFE, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b1, 3'd1, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 3'd1, 8'h55, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 3'd0, 8'h12, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0);

        r = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0);

        // Async reset between edges, then held across edges while INC is requested.
        #2 r = 1'b1;
        #1 check_both("reset_async", RV, 1'b0, RV, 1'b0);
        tick();
        check_both("reset_hold1", RV, 1'b0, RV, 1'b0);
        tick();
        check_both("reset_hold2", RV, 1'b0, RV, 1'b0);
        @(negedge clk) r = 1'b0;
        tick();
        check_both("reset_release_inc", 8'hA6, 1'b0, 8'hA6, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].s, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sin);
            tick();
            check_both($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ec, tbl[i].eqs, tbl[i].ecs);
        end

        // Boundary behaviour of INC/DEC in both wrap and saturate builds.
        drive(1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0); tick();
        check_both("inc_at_ff", 8'h00, 1'b1, 8'hFF, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0); tick();
        check_both("dec_at_00", 8'hFF, 1'b1, 8'h00, 1'b1);

        // Reset in the middle of an INC stream, then counting resumes from RESET_VAL.
        drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h10, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0); tick();
        tick();
        check_both("count_pre", 8'h12, 1'b0, 8'h12, 1'b0);
        #2 r = 1'b1;
        #1 check_both("count_async_rst", RV, 1'b0, RV, 1'b0);
        @(negedge clk) r = 1'b0;
        tick();
        check_both("count_resume1", 8'hA6, 1'b0, 8'hA6, 1'b0);
        tick();
        check_both("count_resume2", 8'hA7, 1'b0, 8'hA7, 1'b0);

        // Randomised phase against the reference model, with occasional async resets.
        mq0 = 8'hA7; mc0 = 0; mq1 = 8'hA7; mc1 = 0;
        for (int n = 0; n < 400; n++) begin
            rsel = $urandom_range(0, 19);
            rclr = (rsel == 0);
            rs_b = (rsel == 1) || (rsel == 2 && $urandom_range(0, 1) == 1);
            ren  = ($urandom_range(0, 7) != 0);
            rm   = $urandom_range(0, 7);
            rd   = $urandom_range(0, 255);
            rs   = $urandom_range(0, 1);
            drive(rclr, rs_b, ren, 3'(rm), 8'(rd), rs[0]);
            model(0, mq0, mc0, rclr, rs_b, ren, rm, rd, rs, nq, nc); mq0 = nq; mc0 = nc;
            model(1, mq1, mc1, rclr, rs_b, ren, rm, rd, rs, nq, nc); mq1 = nq; mc1 = nc;
            tick();
            check_both($sformatf("rand%0d", n), 8'(mq0), mc0[0], 8'(mq1), mc1[0]);
            if ($urandom_range(0, 39) == 0) begin
                r = 1'b1;
                #1;
                check_both($sformatf("rand_rst%0d", n), RV, 1'b0, RV, 1'b0);
                r = 1'b0;
                mq0 = RV; mc0 = 0; mq1 = RV; mc1 = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
